// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, FSM encodings, reset level.
// Pure definitions, no logic; imported by pipe_ctrl and its watchdog.
package pipe_ctrl_pkg;

  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b0;

  // bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  function automatic logic [31:0] redirect_pc(input logic [31:0] exc_type,
                                              input logic [31:0] eret_code,
                                              input logic [31:0] epc,
                                              input logic [31:0] vec);
    return (exc_type == eret_code) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive request-stall cycles, saturating at TIMEOUT_CYCLES.
// Pulse is registered: high the cycle after the count reaches the limit; no backpressure.
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall_active,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // Saturating at the limit keeps a long stall to a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (!i_stall_active) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_timeout <= (r_cnt == CNT_PRE);
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, runs exception drain/flush FSM, watchdog, stall counter.
// stall_o is combinational; flush/new_pc/timeout are registered (exception N -> flush N+1 if bus idle).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE      = 32'h0000_000e,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cnt_o
);

  logic [1:0]  r_state;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cnt;

  logic [1:0]  w_next;
  logic [5:0]  w_stall;
  logic        w_exc;
  logic        w_bus_busy;
  logic        w_wd_active;

  assign w_exc      = (excepttype_i != ZeroWord);
  assign w_bus_busy = stallreq_if_i | stallreq_mem_i;

  always_comb begin
    w_stall = STALL_NONE;
    w_next  = r_state;
    case (r_state)
      RUN: begin
        if (w_exc) begin
          w_stall = STALL_ALL;
          w_next  = w_bus_busy ? DRAIN : FLUSH;
        end else if (stallreq_mem_i) begin
          w_stall = STALL_MEM;
        end else if (stallreq_ex_i) begin
          w_stall = STALL_EX;
        end else if (stallreq_id_i) begin
          w_stall = STALL_ID;
        end else if (stallreq_if_i) begin
          w_stall = STALL_IF;
        end
      end
      DRAIN: begin
        w_stall = STALL_ALL;
        if (!w_bus_busy) w_next = FLUSH;
      end
      FLUSH: begin
        w_stall = STALL_NONE;
        w_next  = RUN;
      end
      default: w_next = RUN;
    endcase
    // Hold nothing while reset is asserted, even if requests are still high.
    if (rst == RstEnable) w_stall = STALL_NONE;
  end

  assign w_wd_active = (r_state == RUN) && !w_exc && (w_stall != STALL_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state     <= RUN;
      r_flush     <= 1'b0;
      r_new_pc    <= ZeroWord;
      r_stall_cnt <= ZeroWord;
    end else begin
      r_state <= w_next;
      r_flush <= (w_next == FLUSH);
      if ((r_state == RUN) && w_exc)
        r_new_pc <= redirect_pc(excepttype_i, ERET_CODE, cp0_epc_i, EXC_VECTOR);
      if (w_stall[0] == Stop)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .i_stall_active (w_wd_active),
    .o_timeout      (stall_timeout_o)
  );

  assign stall_o     = w_stall;
  assign flush_o     = r_flush;
  assign new_pc_o    = r_new_pc;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with an expected-response queue and a per-cycle monitor.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_cnt = 32'h0;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .ERET_CODE     (32'h0000_000e),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_timeout_o(stall_timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs ({mem,ex,id,if}) and queue the outputs expected in that cycle.
  task automatic step(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] es, input logic ef, input logic [31:0] epc_exp,
                      input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    e.st  = es;
    e.fl  = ef;
    e.pc  = epc_exp;
    e.to  = eto;
    e.cnt = exp_cnt;
    q.push_back(e);
    if (es[0]) exp_cnt = exp_cnt + 32'd1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o",         {26'h0, stall_o},        {26'h0, e.st});
      chk("flush_o",         {31'h0, flush_o},        {31'h0, e.fl});
      chk("new_pc_o",        new_pc_o,                e.pc);
      chk("stall_timeout_o", {31'h0, stall_timeout_o}, {31'h0, e.to});
      chk("stall_cnt_o",     stall_cnt_o,             e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = 4'b1000;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
    #13;
    chk("rst_stall",   {26'h0, stall_o}, 32'h0);
    chk("rst_flush",   {31'h0, flush_o}, 32'h0);
    chk("rst_new_pc",  new_pc_o,         32'h0);
    chk("rst_timeout", {31'h0, stall_timeout_o}, 32'h0);
    chk("rst_cnt",     stall_cnt_o,      32'h0);
    stallreq_mem_i = 1'b0;
    #4 rst = 1'b1;

    // Stall priority
    step(4'b0010, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
    step(4'b0110, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0);
    step(4'b1111, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0);
    step(4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

    // Exception with idle bus: freeze, then one-cycle flush to the vector
    step(4'b0110, 32'h1, 32'h0, 6'b111111, 1'b0, 32'h0,  1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b1, 32'h20, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h20, 1'b0);

    // ERET with busy data bus: drain (new exceptions ignored), then flush to EPC
    step(4'b1000, 32'he, 32'h1234, 6'b111111, 1'b0, 32'h20,   1'b0);
    step(4'b1000, 32'h1, 32'h0,    6'b111111, 1'b0, 32'h1234, 1'b0);
    step(4'b1000, 32'h0, 32'h0,    6'b111111, 1'b0, 32'h1234, 1'b0);
    step(4'b0000, 32'h0, 32'h0,    6'b111111, 1'b0, 32'h1234, 1'b0);
    step(4'b0000, 32'h0, 32'h0,    6'b000000, 1'b1, 32'h1234, 1'b0);
    step(4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h1234, 1'b0);

    // Watchdog: 20-cycle stall gives one pulse, in the cycle after the 16th stalled edge
    for (int i = 1; i <= 20; i++)
      step(4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h1234, (i == 17));
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h1234, 1'b0);
    for (int i = 1; i <= 16; i++)
      step(4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h1234, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h1234, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h1234, 1'b0);

    // Stall counter wrap from a preloaded all-ones value
    @(negedge clk);
    #1 force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_stall_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    step(4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h1234, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h1234, 1'b0);

    // Reset during DRAIN discards the pending flush
    step(4'b1000, 32'h1, 32'h0, 6'b111111, 1'b0, 32'h1234, 1'b0);
    step(4'b1000, 32'h0, 32'h0, 6'b111111, 1'b0, 32'h20,   1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("drain_rst_stall",   {26'h0, stall_o}, 32'h0);
    chk("drain_rst_flush",   {31'h0, flush_o}, 32'h0);
    chk("drain_rst_new_pc",  new_pc_o,         32'h0);
    chk("drain_rst_timeout", {31'h0, stall_timeout_o}, 32'h0);
    chk("drain_rst_cnt",     stall_cnt_o,      32'h0);
    stallreq_mem_i = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    exp_cnt = 32'h0;
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
